// File: rtl/tick_scan_pkg.sv
// Shared constants, types and helpers for the tick/scan timebase.
package tick_scan_pkg;

   // Upper bound on multiplexed digits and the index width that covers it
   localparam int unsigned MAX_DIGITS = 8;
   localparam int unsigned IDX_W_MAX  = 3;

   // Number of high scan-counter bits compared against brightness
   localparam int unsigned PWM_BITS = 4;

   // Digit index widened to the largest supported display
   typedef logic [IDX_W_MAX-1:0] digit_sel_t;

   // Width needed to hold 0..n-1, never less than one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : int'($clog2(n));
   endfunction

   // Clock divide ratio between system clock and tick rate
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned tick_hz);
      return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/pulse_div.sv
// Enable-gated modulo-DIV counter emitting a registered one-cycle pulse on terminal count.
module pulse_div
   import tick_scan_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic clock,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic pulse
);

   localparam int unsigned CNT_W = clog2_min1(DIV);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

   if (DIV < 2) begin : g_bad_div
      $error("pulse_div: DIV must be at least 2");
   end

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_pulse;
   logic             w_pulse_nxt;

   // Next count: clear wins, disabled holds, terminal count wraps and fires the pulse
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      if (clr) begin
         w_cnt_nxt = '0;
      end else if (en) begin
         if (r_cnt == LAST_CNT) begin
            w_cnt_nxt   = '0;
            w_pulse_nxt = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end
   end

   // Counter and pulse registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_pulse_nxt;
      end
   end

   assign pulse = r_pulse;

endmodule

// File: rtl/tick_scan_gen.sv
// Timebase tick generator plus free-running multiplexed-display digit scanner.
// Optional macro TICK_SCAN_PWM_EN adds a 4-bit brightness input that duty-cycles
// the active anode within each digit slot.
module tick_scan_gen
   import tick_scan_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 100000000,
   parameter int unsigned TICK_HZ       = 1,
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned SCAN_DIV_BITS = 16
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                enable,
   input  logic                                clear,
   input  logic [NUM_DIGITS-1:0]               digit_mask,
`ifdef TICK_SCAN_PWM_EN
   input  logic [PWM_BITS-1:0]                 brightness,
`endif
   output logic                                tick,
   output logic [NUM_DIGITS-1:0]               an,
   output logic [clog2_min1(NUM_DIGITS)-1:0]   digit_idx
);

   localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
   localparam int unsigned IDX_W = clog2_min1(NUM_DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   if (DIV < 2) begin : g_bad_div
      $error("tick_scan_gen: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
      $error("tick_scan_gen: NUM_DIGITS must be 1..8");
   end
   if (SCAN_DIV_BITS < 4) begin : g_bad_scan
      $error("tick_scan_gen: SCAN_DIV_BITS must be at least 4");
   end

   pulse_div #(
      .DIV (DIV)
   ) u_tick_div (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (enable),
      .clr     (clear),
      .pulse   (tick)
   );

   logic [SCAN_DIV_BITS-1:0] r_scan_cnt;
   logic [SCAN_DIV_BITS-1:0] w_scan_nxt;
   logic [IDX_W-1:0]         r_digit_idx;
   logic [IDX_W-1:0]         w_idx_nxt;
   logic [NUM_DIGITS-1:0]    r_an;
   logic [NUM_DIGITS-1:0]    w_an_nxt;
   logic                     w_lit;

   // Scan counter and digit index advance; clear restarts both at digit 0
   always_comb begin
      w_scan_nxt = r_scan_cnt + SCAN_DIV_BITS'(1);
      w_idx_nxt  = r_digit_idx;
      if (clear) begin
         w_scan_nxt = '0;
         w_idx_nxt  = '0;
      end else if (&r_scan_cnt) begin
         w_idx_nxt = (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + IDX_W'(1);
      end
   end

   // Anode decode from the next index so an and digit_idx change on the same edge
   always_comb begin
`ifdef TICK_SCAN_PWM_EN
      w_lit = (w_scan_nxt[SCAN_DIV_BITS-1 -: PWM_BITS] < brightness);
`else
      w_lit = 1'b1;
`endif
      w_an_nxt = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_lit && digit_mask[i] && (digit_sel_t'(w_idx_nxt) == digit_sel_t'(i))) begin
            w_an_nxt[i] = 1'b0;
         end
      end
   end

   // Scanner state and registered anode enables
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= '0;
         r_an        <= '1;
      end else begin
         r_scan_cnt  <= w_scan_nxt;
         r_digit_idx <= w_idx_nxt;
         r_an        <= w_an_nxt;
      end
   end

   assign an        = r_an;
   assign digit_idx = r_digit_idx;

endmodule

// File: doc/tick_scan_gen.md
Name: tick_scan_gen

Overview:
Parametrised timebase and multiplexed-display scanner. Generates a single-cycle tick at TICK_HZ from the system clock. Independently drives active-low, one-hot anode enables for an N-digit seven-segment display, with a per-digit blanking mask. Sits between the board clock and the clock-keeping/display logic, and provides both the 1 Hz (or other rate) timebase and the digit-select index for the segment mux.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
TICK_HZ, 1, tick output rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2 (elaboration error otherwise)
NUM_DIGITS, 4, number of multiplexed digits, 1..8
SCAN_DIV_BITS, 16, digit slot length is 2^SCAN_DIV_BITS clocks, minimum 4

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  tick counter advances only while high
clear  in  1  synchronous restart of the tick counter and the scanner
digit_mask  in  NUM_DIGITS  1 = digit lit, 0 = digit blanked
tick  out  1  registered one-cycle pulse, period DIV clocks
an  out  NUM_DIGITS  registered anode enables, active low, at most one bit low
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the current digit slot, for the segment mux

Behaviour:
- Reset (reset_n low, asynchronous): tick_cnt=0, tick=0, scan_cnt=0, digit_idx=0, an=all ones.
- Tick counter, width $clog2(DIV):
  - With enable=1: if tick_cnt==DIV-1, tick_cnt<=0 and tick<=1; else tick_cnt<=tick_cnt+1 and tick<=0.
  - With enable=0: tick_cnt holds and tick<=0.
  - The tick period is exactly DIV clocks. The first tick comes DIV clocks after enable rises from reset.
- Scanner:
  - Free-runs regardless of enable, so the display stays lit while paused.
  - scan_cnt increments every clock. On wrap from all ones to 0, digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1.
  - an is registered: an[i]=0 iff i==next digit_idx and digit_mask[i]==1. Otherwise an[i]=1.
  - an therefore updates in the same cycle as digit_idx and is never glitchy.
- digit_mask:
  - Sampled every clock, so a change takes effect on the next an update.
  - Masked digits still consume their time slot and are blanked, not skipped, so the refresh rate is constant.
  - If all mask bits are 0, an is all ones.
- clear:
  - Has priority over enable and over the scan advance.
  - Next cycle: tick_cnt=0, tick=0, scan_cnt=0, digit_idx=0, an reflects digit 0 under the current mask.
  - clear held high keeps this state.
- Simultaneous events:
  - clear together with a terminal count produces no tick.
  - enable falling on the terminal-count cycle produces no tick, and the count holds at DIV-1.
- NUM_DIGITS=1: digit_idx is a constant 0 and an[0]=~digit_mask[0].

Optional Feature:
Macro TICK_SCAN_PWM_EN.
- Defined:
  - Adds an extra input brightness (4 bits).
  - Within each digit slot, the anode is asserted only while scan_cnt[SCAN_DIV_BITS-1 -: 4] < brightness.
  - brightness=0 gives all blank. brightness=15 gives the anode lit 15/16 of the slot.
  - brightness is sampled every clock.
- Undefined: the port is absent and the anode is lit for the full slot.

Decomposition:
- Package tick_scan_pkg:
  - function clog2_min1(n), used for the index and counter widths
  - localparam-style constants for DIV derivation
  - typedef for the digit index
- One natural sub-module: pulse_div.
  - Parameter DIV, inputs clock/reset_n/en/clr, output pulse.
  - Instantiated for the tick counter; the scanner uses an equivalent power-of-two counter inline.

Test Plan:
1. CLK_HZ=10, TICK_HZ=1, enable=1 after reset -> tick high on clock 10, then every 10 clocks, one cycle wide; 5 ticks in 50 clocks.
2. Same config, enable low for 7 clocks starting at count 4 -> next tick delayed by exactly 7 clocks; tick never asserted while enable=0.
3. NUM_DIGITS=4, SCAN_DIV_BITS=4, mask=1111 -> an sequence 1110, 1101, 1011, 0111, 1110, each held 16 clocks; digit_idx 0,1,2,3,0.
4. mask=1010 -> an sequence 1111, 1101, 1111, 0111; mask=0000 -> an=1111 constantly; slot timing unchanged.
5. clear pulsed mid-slot at digit 2 with tick_cnt=6 -> next cycle digit_idx=0, an=1110, tick_cnt=0; next tick DIV clocks after clear is released; reset_n pulsed mid-slot -> an=1111 immediately, without waiting for a clock.
6. With TICK_SCAN_PWM_EN, SCAN_DIV_BITS=6, brightness=4 -> each digit's anode is low for 16 of its 64 clocks (first 16); brightness=0 -> an=all ones.
